// File: rtl/ez90_renamer_fl.sv
// Free-list register renamer: speculative and committed map tables plus a circular
// free list, renaming one uop per cycle and reclaiming stale physical registers at commit.
package ez90_pkg;
    localparam int EZ90_AREG_W = 5;
    localparam int EZ90_PREG_W = 6;

    typedef struct packed {
        logic [6:0]             opcode;
        logic [EZ90_AREG_W-1:0] rs1;
        logic [EZ90_AREG_W-1:0] rs2;
        logic [EZ90_AREG_W-1:0] rd;
        logic                   rd_valid;
    } ez90_uop_t;

    typedef struct packed {
        ez90_uop_t              uop;
        logic [EZ90_PREG_W-1:0] prs1;
        logic [EZ90_PREG_W-1:0] prs2;
        logic [EZ90_PREG_W-1:0] prd;
    } ez90_uop_rn_t;
endpackage

module ez90_renamer_fl
    import ez90_pkg::*;
#(
    parameter int NUM_ARCH   = 32,
    parameter int NUM_PREG   = 64,
    parameter int PREG_W     = $clog2(NUM_PREG),
    parameter int ZERO_FIXED = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    input  ez90_uop_t                   in_uop,
    output logic                        in_ready,
    output logic                        out_valid,
    output ez90_uop_rn_t                out_uop,
    output logic [PREG_W-1:0]           out_stale_prd,
    input  logic                        out_ready,
    input  logic                        commit_valid,
    input  logic                        commit_rd_valid,
    input  logic [$clog2(NUM_ARCH)-1:0] commit_rd,
    input  logic [PREG_W-1:0]           commit_prd,
    input  logic [PREG_W-1:0]           commit_stale_prd,
    output logic [$clog2(NUM_PREG):0]   free_count
);

    localparam int FL_DEPTH = NUM_PREG - NUM_ARCH;
    localparam int IDX_W    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam int PTR_W    = IDX_W + 1;
    localparam int CNT_W    = $clog2(NUM_PREG) + 1;

    // Pointers are {wrap, index}; the index wraps at FL_DEPTH so the depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        if (p[IDX_W-1:0] == IDX_W'(FL_DEPTH - 1)) begin
            ptrInc = {~p[PTR_W-1], {IDX_W{1'b0}}};
        end else begin
            ptrInc = p + PTR_W'(1);
        end
    endfunction

    function automatic logic [CNT_W-1:0] ptrDist(input logic [PTR_W-1:0] hi, input logic [PTR_W-1:0] lo);
        if (hi[PTR_W-1] == lo[PTR_W-1]) begin
            ptrDist = CNT_W'(hi[IDX_W-1:0]) - CNT_W'(lo[IDX_W-1:0]);
        end else begin
            ptrDist = CNT_W'(FL_DEPTH) + CNT_W'(hi[IDX_W-1:0]) - CNT_W'(lo[IDX_W-1:0]);
        end
    endfunction

    logic [PREG_W-1:0] specMap_q   [NUM_ARCH];
    logic [PREG_W-1:0] specMap_d   [NUM_ARCH];
    logic [PREG_W-1:0] commitMap_q [NUM_ARCH];
    logic [PREG_W-1:0] commitMap_d [NUM_ARCH];
    logic [PREG_W-1:0] fl_q        [FL_DEPTH];
    logic [PTR_W-1:0]  specHead_q, specHead_d;
    logic [PTR_W-1:0]  commitHead_q, commitHead_d;
    logic [PTR_W-1:0]  tail_q, tail_d;

    logic              alloc;
    logic              stall;
    logic              fire;
    logic              commitDo;
    logic [PREG_W-1:0] allocPrd;
    logic [CNT_W-1:0]  commitSpan;

    always_comb begin
        alloc      = in_uop.rd_valid && !((ZERO_FIXED != 0) && (in_uop.rd == '0));
        free_count = ptrDist(tail_q, specHead_q);
        commitSpan = ptrDist(tail_q, commitHead_q);
        stall      = alloc && (free_count == '0);
        in_ready   = out_ready && !stall && !flush;
        out_valid  = in_valid && !stall && !flush;
        fire       = in_valid && in_ready;
        allocPrd   = fl_q[specHead_q[IDX_W-1:0]];
        commitDo   = commit_valid && commit_rd_valid && !((ZERO_FIXED != 0) && (commit_rd == '0));

        out_uop       = '0;
        out_uop.uop   = in_uop;
        out_uop.prs1  = specMap_q[in_uop.rs1];
        out_uop.prs2  = specMap_q[in_uop.rs2];
        out_uop.prd   = alloc ? allocPrd : '0;
        out_stale_prd = alloc ? specMap_q[in_uop.rd] : '0;
    end

    // Commit updates are computed first so a same-cycle flush restores the post-commit state.
    always_comb begin
        commitMap_d  = commitMap_q;
        commitHead_d = commitHead_q;
        tail_d       = tail_q;
        if (commitDo) begin
            commitMap_d[commit_rd] = commit_prd;
            commitHead_d           = ptrInc(commitHead_q);
            tail_d                 = ptrInc(tail_q);
        end

        specMap_d  = specMap_q;
        specHead_d = specHead_q;
        if (flush) begin
            specMap_d  = commitMap_d;
            specHead_d = commitHead_d;
        end else if (fire && alloc) begin
            specMap_d[in_uop.rd] = allocPrd;
            specHead_d           = ptrInc(specHead_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_ARCH; r++) begin
                specMap_q[r]   <= PREG_W'(r);
                commitMap_q[r] <= PREG_W'(r);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= PREG_W'(NUM_ARCH + i);
            end
            specHead_q   <= '0;
            commitHead_q <= '0;
            tail_q       <= {1'b1, {IDX_W{1'b0}}};
        end else begin
            specMap_q    <= specMap_d;
            commitMap_q  <= commitMap_d;
            specHead_q   <= specHead_d;
            commitHead_q <= commitHead_d;
            tail_q       <= tail_d;
            if (commitDo) begin
                fl_q[tail_q[IDX_W-1:0]] <= commit_stale_prd;
            end
        end
    end

    // Every committed pointer advance is paired with a tail push, so the list never overflows.
    assert property (@(posedge clk) disable iff (rst) commitSpan == CNT_W'(FL_DEPTH));
    assert property (@(posedge clk) disable iff (rst) free_count <= CNT_W'(FL_DEPTH));

endmodule

// File: tb/tb_ez90_renamer_fl.sv
// Self-checking bench for ez90_renamer_fl: directed scenarios with literal expectations,
// then randomized rename/commit/flush traffic compared against a queue-based model.
module tb_ez90_renamer_fl;
    import ez90_pkg::*;

    localparam int NUM_ARCH = 32;
    localparam int NUM_PREG = 64;
    localparam int FL_DEPTH = NUM_PREG - NUM_ARCH;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush;
    logic         inValid;
    ez90_uop_t    inUop;
    logic         inReady;
    logic         outValid;
    ez90_uop_rn_t outUop;
    logic [5:0]   outStalePrd;
    logic         outReady;
    logic         commitValid;
    logic         commitRdValid;
    logic [4:0]   commitRd;
    logic [5:0]   commitPrd;
    logic [5:0]   commitStalePrd;
    logic [6:0]   freeCount;

    ez90_renamer_fl #(
        .NUM_ARCH(NUM_ARCH), .NUM_PREG(NUM_PREG), .PREG_W(6), .ZERO_FIXED(1)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_uop(inUop), .in_ready(inReady),
        .out_valid(outValid), .out_uop(outUop), .out_stale_prd(outStalePrd),
        .out_ready(outReady),
        .commit_valid(commitValid), .commit_rd_valid(commitRdValid), .commit_rd(commitRd),
        .commit_prd(commitPrd), .commit_stale_prd(commitStalePrd),
        .free_count(freeCount)
    );

    always #5 clk = ~clk;

    // Model: fullList holds the FL_DEPTH registers from the committed head onward;
    // specOff counts how many of them speculative renames have already handed out.
    typedef struct {
        int rd;
        int prd;
        int stale;
    } robEntry_t;

    int        mSpec   [NUM_ARCH];
    int        mCommit [NUM_ARCH];
    int        fullList[$];
    int        specOff;
    robEntry_t rob[$];

    int passCount  = 0;
    int checkCount = 0;

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < NUM_ARCH; r++) begin
            mSpec[r]   = r;
            mCommit[r] = r;
        end
        fullList.delete();
        for (int i = 0; i < FL_DEPTH; i++) fullList.push_back(NUM_ARCH + i);
        specOff = 0;
        rob.delete();
    endtask

    function automatic bit modelAlloc();
        return inUop.rd_valid && (inUop.rd != 0);
    endfunction

    function automatic bit modelStall();
        return modelAlloc() && (FL_DEPTH - specOff == 0);
    endfunction

    function automatic int modelPrd();
        return modelAlloc() ? fullList[specOff % FL_DEPTH] : 0;
    endfunction

    task automatic checkOutput();
        bit expRdy;
        bit expVld;
        expRdy = outReady && !modelStall() && !flush;
        expVld = inValid && !modelStall() && !flush;
        checkVal("free_count", 32'(freeCount), 32'(FL_DEPTH - specOff));
        checkVal("in_ready", 32'(inReady), 32'(expRdy));
        checkVal("out_valid", 32'(outValid), 32'(expVld));
        if (expVld) begin
            checkVal("prs1", 32'(outUop.prs1), 32'(mSpec[inUop.rs1]));
            checkVal("prs2", 32'(outUop.prs2), 32'(mSpec[inUop.rs2]));
            checkVal("prd", 32'(outUop.prd), 32'(modelPrd()));
            checkVal("stale_prd", 32'(outStalePrd), 32'(modelAlloc() ? mSpec[inUop.rd] : 0));
            checkVal("uop_passthru", 32'(outUop.uop), 32'(inUop));
        end
    endtask

    task automatic modelUpdate();
        bit fire;
        bit commitDo;
        int prd;
        fire     = inValid && outReady && !modelStall() && !flush;
        commitDo = commitValid && commitRdValid && (commitRd != 0);
        prd      = modelPrd();
        if (fire && modelAlloc()) begin
            rob.push_back('{rd: int'(inUop.rd), prd: prd, stale: mSpec[inUop.rd]});
            mSpec[inUop.rd] = prd;
            specOff++;
        end
        if (commitDo) begin
            mCommit[commitRd] = int'(commitPrd);
            void'(fullList.pop_front());
            fullList.push_back(int'(commitStalePrd));
            specOff--;
        end
        if (flush) begin
            mSpec   = mCommit;
            specOff = 0;
            rob.delete();
        end
    endtask

    task automatic driveCommit(input bit v, input bit rdv, input int rd, input int prd, input int stale);
        commitValid    = v;
        commitRdValid  = rdv;
        commitRd       = 5'(rd);
        commitPrd      = 6'(prd);
        commitStalePrd = 6'(stale);
    endtask

    task automatic commitFront(input int staleOverride);
        robEntry_t e;
        e = rob.pop_front();
        driveCommit(1'b1, 1'b1, e.rd, e.prd, (staleOverride >= 0) ? staleOverride : e.stale);
    endtask

    task automatic applyStimulus(input bit v, input int rs1, input int rs2, input int rd,
                                 input bit rdv, input bit ordy, input bit fl);
        inValid        = v;
        inUop.opcode   = 7'($urandom_range(0, 127));
        inUop.rs1      = 5'(rs1);
        inUop.rs2      = 5'(rs2);
        inUop.rd       = 5'(rd);
        inUop.rd_valid = rdv;
        outReady       = ordy;
        flush          = fl;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic endCycle();
        @(posedge clk);
        modelUpdate();
        #1;
        driveCommit(1'b0, 1'b0, 0, 0, 0);
        flush = 1'b0;
    endtask

    task automatic doReset();
        inValid  = 1'b0;
        inUop    = '0;
        outReady = 1'b1;
        flush    = 1'b0;
        driveCommit(1'b0, 1'b0, 0, 0, 0);
        #1;
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        doReset();

        $display("[TB] reset state and four renames");
        rst = 1'b1;
        #1;
        checkVal("reset_free_count", 32'(freeCount), 32'd32);
        checkVal("reset_in_ready", 32'(inReady), 32'd1);
        checkVal("reset_out_valid", 32'(outValid), 32'd0);
        checkVal("reset_out_uop", 32'(outUop), 32'd0);
        checkVal("reset_stale", 32'(outStalePrd), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 0, 0, i, 1'b1, 1'b1, 1'b0);
            checkVal("four_prd", 32'(outUop.prd), 32'(31 + i));
            checkVal("four_stale", 32'(outStalePrd), 32'(i));
            endCycle();
        end
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkVal("four_free_count", 32'(freeCount), 32'd28);
        endCycle();

        $display("[TB] source/destination collision");
        doReset();
        applyStimulus(1'b1, 5, 0, 5, 1'b1, 1'b1, 1'b0);
        checkVal("coll_prs1_old", 32'(outUop.prs1), 32'd5);
        checkVal("coll_prd", 32'(outUop.prd), 32'd32);
        endCycle();
        applyStimulus(1'b1, 5, 0, 0, 1'b0, 1'b1, 1'b0);
        checkVal("coll_prs1_new", 32'(outUop.prs1), 32'd32);
        endCycle();

        $display("[TB] exhaustion and recovery");
        doReset();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, $urandom_range(0, 31), $urandom_range(0, 31), (i % 31) + 1, 1'b1, 1'b1, 1'b0);
            endCycle();
        end
        applyStimulus(1'b1, 0, 0, 7, 1'b1, 1'b1, 1'b0);
        checkVal("exh_free_count", 32'(freeCount), 32'd0);
        checkVal("exh_in_ready", 32'(inReady), 32'd0);
        checkVal("exh_out_valid", 32'(outValid), 32'd0);
        endCycle();
        applyStimulus(1'b1, 3, 4, 9, 1'b0, 1'b1, 1'b0);
        checkVal("exh_nonalloc_ready", 32'(inReady), 32'd1);
        endCycle();
        commitFront(3);
        applyStimulus(1'b1, 0, 0, 7, 1'b1, 1'b1, 1'b0);
        checkVal("exh_commit_cycle_ready", 32'(inReady), 32'd0);
        endCycle();
        applyStimulus(1'b1, 0, 0, 7, 1'b1, 1'b1, 1'b0);
        checkVal("exh_recover_ready", 32'(inReady), 32'd1);
        checkVal("exh_recover_prd", 32'(outUop.prd), 32'd3);
        endCycle();

        $display("[TB] flush recovery");
        doReset();
        applyStimulus(1'b1, 0, 0, 1, 1'b1, 1'b1, 1'b0);
        checkVal("flush_first_prd", 32'(outUop.prd), 32'd32);
        endCycle();
        commitFront(-1);
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        endCycle();
        applyStimulus(1'b1, 0, 0, 1, 1'b1, 1'b1, 1'b0);
        checkVal("flush_second_prd", 32'(outUop.prd), 32'd33);
        endCycle();
        applyStimulus(1'b1, 0, 0, 1, 1'b1, 1'b1, 1'b1);
        checkVal("flush_out_valid", 32'(outValid), 32'd0);
        endCycle();
        applyStimulus(1'b1, 1, 0, 2, 1'b1, 1'b1, 1'b0);
        checkVal("flush_prs1", 32'(outUop.prs1), 32'd32);
        checkVal("flush_prd", 32'(outUop.prd), 32'd33);
        checkVal("flush_free_count", 32'(freeCount), 32'd32);
        endCycle();

        $display("[TB] zero register");
        doReset();
        applyStimulus(1'b1, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        checkVal("zero_prd", 32'(outUop.prd), 32'd0);
        checkVal("zero_stale", 32'(outStalePrd), 32'd0);
        endCycle();
        applyStimulus(1'b1, 0, 0, 5, 1'b1, 1'b1, 1'b0);
        checkVal("zero_map", 32'(outUop.prs1), 32'd0);
        checkVal("zero_free_count", 32'(freeCount), 32'd32);
        checkVal("zero_next_prd", 32'(outUop.prd), 32'd32);
        endCycle();

        $display("[TB] concurrent commit and flush");
        doReset();
        applyStimulus(1'b1, 0, 0, 3, 1'b1, 1'b1, 1'b0);
        endCycle();
        commitFront(-1);
        applyStimulus(1'b1, 0, 0, 4, 1'b1, 1'b1, 1'b1);
        endCycle();
        applyStimulus(1'b1, 3, 0, 0, 1'b0, 1'b1, 1'b0);
        checkVal("cf_prs1", 32'(outUop.prs1), 32'd32);
        checkVal("cf_free_count", 32'(freeCount), 32'd32);
        endCycle();

        $display("[TB] reset mid-operation");
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 0, 0, i, 1'b1, 1'b1, 1'b0);
            endCycle();
        end
        inValid        = 1'b1;
        inUop.rs1      = 5'd1;
        inUop.rs2      = 5'd2;
        inUop.rd_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checkVal("midrst_prs1", 32'(outUop.prs1), 32'd1);
        checkVal("midrst_prs2", 32'(outUop.prs2), 32'd2);
        checkVal("midrst_free_count", 32'(freeCount), 32'd32);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            if (rob.size() > 0 && $urandom_range(0, 99) < 45) begin
                commitFront(-1);
            end else if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1) driveCommit(1'b1, 1'b1, 0, $urandom_range(0, 63), $urandom_range(0, 63));
                else driveCommit(1'b1, 1'b0, $urandom_range(1, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            end
            applyStimulus($urandom_range(0, 99) < 75, $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 85,
                          $urandom_range(0, 99) < 3);
            endCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
